// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Two-requester arbiter in front of the single-port word memory of the RV32I core.
// Port IF is instruction fetch (read-only) and port D is load/store. At most one
// request reaches the memory per cycle. The memory is driven combinationally, and
// each port gets its response in a register one cycle after the request is accepted.
// Misaligned or out-of-range requests never reach the memory. They are answered
// with rsp_err set instead.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   -> a tie (both ports valid) goes to the port that did not win last
//   undefined -> fixed priority, so D always wins a tie
module mem_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req_valid,
  output logic             if_req_ready,
  input  logic [WIDTH-1:0] if_req_addr,
  output logic             if_rsp_valid,
  output logic [WIDTH-1:0] if_rsp_data,
  output logic             if_rsp_err,
  input  logic             d_req_valid,
  output logic             d_req_ready,
  input  logic [WIDTH-1:0] d_req_addr,
  input  logic             d_req_we,
  input  logic [WIDTH-1:0] d_req_wdata,
  output logic             d_rsp_valid,
  output logic [WIDTH-1:0] d_rsp_data,
  output logic             d_rsp_err,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_ld,
  output logic             mem_st,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  // Records which port won the most recent accepted handshake.
  typedef enum logic [0:0] {
    LAST_IF = 1'b0,
    LAST_D  = 1'b1
  } last_grant_e;

  // An address is legal only if it is word-aligned and its word index is inside the memory.
  function automatic logic addr_legal(input logic [WIDTH-1:0] addr);
    logic [WIDTH-1:0] word_idx;
    word_idx   = addr >> 2'd2;
    addr_legal = (addr[1:0] == 2'b00) && (word_idx < WIDTH'(DEPTH));
  endfunction

  last_grant_e      last_grant_q, last_grant_d;
  logic             grant_if_s, grant_d_s;
  logic             if_legal_s, d_legal_s;

  logic             if_rsp_valid_q, if_rsp_valid_d;
  logic [WIDTH-1:0] if_rsp_data_q,  if_rsp_data_d;
  logic             if_rsp_err_q,   if_rsp_err_d;
  logic             d_rsp_valid_q,  d_rsp_valid_d;
  logic [WIDTH-1:0] d_rsp_data_q,   d_rsp_data_d;
  logic             d_rsp_err_q,    d_rsp_err_d;

  assign if_legal_s = addr_legal(if_req_addr);
  assign d_legal_s  = addr_legal(d_req_addr);

  // Grant selection: zero or one port wins, and nothing is granted while reset is high.
  always_comb begin
    grant_if_s = 1'b0;
    grant_d_s  = 1'b0;
    if (rst) begin
      grant_if_s = 1'b0;
      grant_d_s  = 1'b0;
    end else if (if_req_valid && d_req_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (last_grant_q == LAST_D) begin
        grant_if_s = 1'b1;
      end else begin
        grant_d_s = 1'b1;
      end
`else
      grant_d_s = 1'b1;
`endif
    end else if (if_req_valid) begin
      grant_if_s = 1'b1;
    end else if (d_req_valid) begin
      grant_d_s = 1'b1;
    end else begin
      grant_if_s = 1'b0;
      grant_d_s  = 1'b0;
    end
  end

  assign if_req_ready = grant_if_s;
  assign d_req_ready  = grant_d_s;

  // Priority pointer next state: it moves only when a handshake completes.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_if_s) begin
      last_grant_d = LAST_IF;
    end else if (grant_d_s) begin
      last_grant_d = LAST_D;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Memory drive: only a granted, legal request produces a load or store strobe.
  always_comb begin
    mem_addr  = {WIDTH{1'b0}};
    mem_ld    = 1'b0;
    mem_st    = 1'b0;
    mem_wdata = {WIDTH{1'b0}};
    if (grant_if_s) begin
      if (if_legal_s) begin
        mem_addr = if_req_addr;
        mem_ld   = 1'b1;
      end else begin
        mem_ld = 1'b0;
      end
    end else if (grant_d_s) begin
      if (d_legal_s) begin
        mem_addr = d_req_addr;
        if (d_req_we) begin
          mem_st    = 1'b1;
          mem_wdata = d_req_wdata;
        end else begin
          mem_ld = 1'b1;
        end
      end else begin
        mem_st = 1'b0;
      end
    end else begin
      mem_addr = {WIDTH{1'b0}};
    end
  end

  // Response next state: read data is captured only for legal loads, and it is zero otherwise.
  always_comb begin
    if_rsp_valid_d = grant_if_s;
    if_rsp_err_d   = grant_if_s && !if_legal_s;
    if_rsp_data_d  = {WIDTH{1'b0}};
    d_rsp_valid_d  = grant_d_s;
    d_rsp_err_d    = grant_d_s && !d_legal_s;
    d_rsp_data_d   = {WIDTH{1'b0}};
    if (grant_if_s && if_legal_s) begin
      if_rsp_data_d = mem_rdata;
    end else begin
      if_rsp_data_d = {WIDTH{1'b0}};
    end
    if (grant_d_s && d_legal_s && !d_req_we) begin
      d_rsp_data_d = mem_rdata;
    end else begin
      d_rsp_data_d = {WIDTH{1'b0}};
    end
  end

  // State registers: response holders and the priority pointer. Reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q   <= LAST_D;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= {WIDTH{1'b0}};
      if_rsp_err_q   <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      d_rsp_data_q   <= {WIDTH{1'b0}};
      d_rsp_err_q    <= 1'b0;
    end else begin
      last_grant_q   <= last_grant_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      if_rsp_err_q   <= if_rsp_err_d;
      d_rsp_valid_q  <= d_rsp_valid_d;
      d_rsp_data_q   <= d_rsp_data_d;
      d_rsp_err_q    <= d_rsp_err_d;
    end
  end

  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign if_rsp_err   = if_rsp_err_q;
  assign d_rsp_valid  = d_rsp_valid_q;
  assign d_rsp_data   = d_rsp_data_q;
  assign d_rsp_err    = d_rsp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. It runs a directed sequence followed by random traffic.
// A transaction-level reference model tracks the memory contents and the winner of each cycle.
// The bench also models the memory itself: reads are combinational and writes land at the clock edge.
module tb_mem_port_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 256;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam logic [3:0] TIE_D_LOG  = 4'b0101;
  localparam logic       TIE_IF_EXP = 1'b1;
`else
  localparam logic [3:0] TIE_D_LOG  = 4'b1111;
  localparam logic       TIE_IF_EXP = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
  logic [WIDTH-1:0] if_req_addr, if_rsp_data;
  logic             d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_err;
  logic [WIDTH-1:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic [WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;
  logic             mem_ld, mem_st;

  logic [31:0] env_mem [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  bit          m_last_d;
  int          n_vec;
  int          n_cmp;
  int          n_bad;
  logic        last_if_rdy, last_d_rdy, last_mem_st, last_mem_ld;
  logic [3:0]  tie_log;
  logic [31:0] init_w17;

  mem_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .mem_addr(mem_addr), .mem_ld(mem_ld), .mem_st(mem_st),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem_ld ? env_mem[mem_addr[9:2]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return ((a % 4) == 0) && ((a / 4) < DEPTH);
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k == 0) return ($urandom_range(0, 15) << 2) | $urandom_range(1, 3);
    else if (k == 1) return 32'(DEPTH * 4) + ($urandom_range(0, 1023) << 2);
    else return $urandom_range(0, 15) << 2;
  endfunction

  // One clock cycle: drive the inputs at the negedge, check the combinational outputs,
  // then check the registered responses just after the posedge.
  task automatic step(input logic r, input logic iv, input logic [31:0] ia,
                      input logic dv, input logic [31:0] da, input logic dwe,
                      input logic [31:0] dwd);
    int          win;
    bit          il, dl;
    logic        e_ld, e_st, e_ifv, e_ife, e_dv, e_de, st_c;
    logic [31:0] e_ifd, e_dd, sta_c, stw_c;
    rst = r; if_req_valid = iv; if_req_addr = ia;
    d_req_valid = dv; d_req_addr = da; d_req_we = dwe; d_req_wdata = dwd;
    n_vec++;
    #1;
    il = legal(ia);
    dl = legal(da);
    if (r) win = 0;
    else if (iv && dv) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win = m_last_d ? 1 : 2;
`else
      win = 2;
`endif
    end
    else if (iv) win = 1;
    else if (dv) win = 2;
    else win = 0;
    e_ld = (win == 1 && il) || (win == 2 && dl && !dwe);
    e_st = (win == 2 && dl && dwe);
    chk("if_req_ready", {31'b0, if_req_ready}, {31'b0, win == 1});
    chk("d_req_ready", {31'b0, d_req_ready}, {31'b0, win == 2});
    chk("mem_ld", {31'b0, mem_ld}, {31'b0, e_ld});
    chk("mem_st", {31'b0, mem_st}, {31'b0, e_st});
    if (e_ld || e_st) chk("mem_addr", mem_addr, (win == 1) ? ia : da);
    if (e_st) chk("mem_wdata", mem_wdata, dwd);
    if (win == 0) begin
      chk("idle_mem_addr", mem_addr, 32'h0);
      chk("idle_mem_wdata", mem_wdata, 32'h0);
    end
    e_ifv = (win == 1);
    e_ife = (win == 1) && !il;
    e_ifd = (win == 1 && il) ? ref_mem[ia / 4] : 32'h0;
    e_dv  = (win == 2);
    e_de  = (win == 2) && !dl;
    e_dd  = (win == 2 && dl && !dwe) ? ref_mem[da / 4] : 32'h0;
    last_if_rdy = if_req_ready;
    last_d_rdy  = d_req_ready;
    last_mem_st = mem_st;
    last_mem_ld = mem_ld;
    tie_log     = {tie_log[2:0], d_req_ready};
    st_c  = mem_st;
    sta_c = mem_addr;
    stw_c = mem_wdata;
    if (e_st) ref_mem[da / 4] = dwd;
    if (r) m_last_d = 1'b1;
    else if (win == 1) m_last_d = 1'b0;
    else if (win == 2) m_last_d = 1'b1;
    @(posedge clk);
    #1;
    if (st_c) env_mem[sta_c[9:2]] = stw_c;
    chk("if_rsp_valid", {31'b0, if_rsp_valid}, {31'b0, e_ifv});
    chk("if_rsp_err", {31'b0, if_rsp_err}, {31'b0, e_ife});
    chk("if_rsp_data", if_rsp_data, e_ifd);
    chk("d_rsp_valid", {31'b0, d_rsp_valid}, {31'b0, e_dv});
    chk("d_rsp_err", {31'b0, d_rsp_err}, {31'b0, e_de});
    chk("d_rsp_data", d_rsp_data, e_dd);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] v;
    n_vec = 0; n_cmp = 0; n_bad = 0; m_last_d = 1'b1; tie_log = 4'b0;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    env_mem[2] = 32'hDEADBEEF;
    ref_mem[2] = 32'hDEADBEEF;
    init_w17   = env_mem[17];

    // Reset with both ports idle.
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    // IF fetch of word 2.
    step(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("if_fetch_ready", {31'b0, last_if_rdy}, 32'h1);
    chk("if_fetch_data", if_rsp_data, 32'hDEADBEEF);

    // A store followed by a load from the same address on the next cycle.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h68, 1'b1, 32'h12345678);
    chk("store_mem_st", {31'b0, last_mem_st}, 32'h1);
    chk("store_rsp_data", d_rsp_data, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h68, 1'b0, 32'h0);
    chk("load_after_store", d_rsp_data, 32'h12345678);

    // Both ports valid for four cycles in a row.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 1'b0, 32'h0);
    chk("tie_grant_seq", {28'b0, tie_log}, {28'b0, TIE_D_LOG});

    // Illegal requests: a misaligned D load, then an out-of-range IF fetch.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h6, 1'b0, 32'h0);
    chk("misalign_no_ld", {31'b0, last_mem_ld}, 32'h0);
    chk("misalign_err", {31'b0, d_rsp_err}, 32'h1);
    step(1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("range_no_ld", {31'b0, last_mem_ld}, 32'h0);
    chk("range_err", {31'b0, if_rsp_err}, 32'h1);

    // Reset is asserted in the cycle a D store is presented.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h44, 1'b1, 32'h0000CAFE);
    chk("rst_drop_rsp", {31'b0, d_rsp_valid}, 32'h0);
    chk("rst_store_dropped", env_mem[17], init_w17);
    step(1'b0, 1'b1, 32'h10, 1'b1, 32'h44, 1'b0, 32'h0);
    chk("tie_after_rst", {31'b0, last_if_rdy}, {31'b0, TIE_IF_EXP});
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h44, 1'b0, 32'h0);

    // Random traffic checked against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), rand_addr(),
           1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
